// File: rtl/conv_pkg.sv
// Shared definitions for the convolution input loader.
//   - default sample width and memory address width
//   - shape encoding for the latched cfg_shape bit
//   - loader FSM state encoding (also exposed on the loader's state_dbg port)
package conv_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 5;

  localparam logic SHAPE_FULL = 1'b0;
  localparam logic SHAPE_SAME = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_X    = 3'd1,
    ST_LOAD_H    = 3'd2,
    ST_START     = 3'd3,
    ST_WAIT_BUSY = 3'd4,
    ST_WAIT_DONE = 3'd5
  } loader_state_t;

endpackage

// File: rtl/conv_len_counter.sv
// Up-counter with synchronous clear and enable, plus a terminal-count flag.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to zero (wins over en)
//   en         : increment by one
//   len        : sequence length the counter is compared against
//   count      : current count
//   tc         : high while count == len-1, i.e. the next increment is the last
module conv_len_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] len,
  output logic [W-1:0] count,
  output logic         tc
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  // Compare count+1 against len so a zero length never underflows.
  assign tc = ((count + ONE) == len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/conv_input_loader.sv
// Input loader in front of the convolution FSM.
// Takes a configuration word, streams len_x samples into X memory and len_h
// coefficients into H memory, pulses start, then follows conv_busy until the
// convolution completes and pulses loader_done.
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high; ready depends only on the loader state, never on valid.
// Ports:
//   clk, rst_n, abort            : clock, async active-low reset, sync soft clear
//   cfg_valid/cfg_ready/cfg_*    : configuration handshake; cfg_err pulses on reject
//   in_valid/in_ready/in_data    : sample stream
//   x_we/h_we/mem_addr/mem_wdata : registered memory write port (shared address)
//   len_x/len_h/len_y/shape      : latched geometry held for the datapath
//   start/conv_busy              : convolution FSM control
//   loader_busy/loader_done      : loader status
//   state_dbg                    : current loader state encoding
module conv_input_loader
  import conv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              abort,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ADDR_W:0]   cfg_len_x,
  input  logic [ADDR_W:0]   cfg_len_h,
  input  logic              cfg_shape,
  output logic              cfg_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              x_we,
  output logic              h_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W:0]   len_x,
  output logic [ADDR_W:0]   len_h,
  output logic [ADDR_W+1:0] len_y,
  output logic              shape,
  output logic              start,
  input  logic              conv_busy,
  output logic              loader_busy,
  output logic              loader_done,
  output logic [2:0]        state_dbg
);

  localparam int              MAX_LEN_I = 1 << ADDR_W;
  localparam logic [ADDR_W:0] MAX_LEN   = (ADDR_W+1)'(MAX_LEN_I);
  localparam logic [ADDR_W+1:0] ONE_Y   = {{(ADDR_W+1){1'b0}}, 1'b1};

  loader_state_t     state;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   cnt_len;
  logic              cnt_tc;
  logic              cnt_clr;
  logic              cnt_en;
  logic              in_load;
  logic              in_acc;
  logic              cfg_bad;
  logic              cfg_acc;
  logic [ADDR_W+1:0] len_y_next;

  assign cfg_ready   = (state == ST_IDLE);
  assign in_load     = (state == ST_LOAD_X) || (state == ST_LOAD_H);
  assign in_ready    = in_load;
  assign loader_busy = (state != ST_IDLE);
  assign state_dbg   = state;

  assign in_acc  = in_valid && in_load;
  assign cfg_bad = (cfg_len_x == '0) || (cfg_len_x > MAX_LEN) ||
                   (cfg_len_h == '0) || (cfg_len_h > MAX_LEN);
  assign cfg_acc = cfg_ready && cfg_valid && !cfg_bad;

  // Full output length needs one extra bit: 2*2**ADDR_W - 1 at most.
  assign len_y_next = (cfg_shape == SHAPE_SAME) ? {1'b0, cfg_len_x}
                    : ({1'b0, cfg_len_x} + {1'b0, cfg_len_h} - ONE_Y);

  // One counter serves both load phases; it restarts at the X->H boundary.
  assign cnt_len = (state == ST_LOAD_H) ? len_h : len_x;
  assign cnt_clr = abort || cfg_acc || ((state == ST_LOAD_X) && in_acc && cnt_tc);
  assign cnt_en  = in_acc;

  conv_len_counter #(.W(ADDR_W+1)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .len   (cnt_len),
    .count (cnt),
    .tc    (cnt_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cfg_err     <= 1'b0;
      x_we        <= 1'b0;
      h_we        <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      len_x       <= '0;
      len_h       <= '0;
      len_y       <= '0;
      shape       <= 1'b0;
      start       <= 1'b0;
      loader_done <= 1'b0;
    end else begin
      // Pulse outputs default low; abort therefore suppresses them next cycle.
      cfg_err     <= 1'b0;
      x_we        <= 1'b0;
      h_we        <= 1'b0;
      start       <= 1'b0;
      loader_done <= 1'b0;
      if (abort) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cfg_valid) begin
              if (cfg_bad) begin
                cfg_err <= 1'b1;
              end else begin
                len_x <= cfg_len_x;
                len_h <= cfg_len_h;
                len_y <= len_y_next;
                shape <= cfg_shape;
                state <= ST_LOAD_X;
              end
            end
          end
          ST_LOAD_X: begin
            if (in_acc) begin
              x_we      <= 1'b1;
              mem_addr  <= cnt[ADDR_W-1:0];
              mem_wdata <= in_data;
              if (cnt_tc) state <= ST_LOAD_H;
            end
          end
          ST_LOAD_H: begin
            if (in_acc) begin
              h_we      <= 1'b1;
              mem_addr  <= cnt[ADDR_W-1:0];
              mem_wdata <= in_data;
              if (cnt_tc) begin
                // start lands in the same cycle as the last H write.
                start <= 1'b1;
                state <= ST_START;
              end
            end
          end
          ST_START: begin
            state <= ST_WAIT_BUSY;
          end
          ST_WAIT_BUSY: begin
            if (conv_busy) state <= ST_WAIT_DONE;
          end
          ST_WAIT_DONE: begin
            if (!conv_busy) begin
              loader_done <= 1'b1;
              state       <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_input_loader.sv
module tb_conv_input_loader;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int SB_W   = 2 + ADDR_W + DATA_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W:0]   lenx_t;
  typedef logic [ADDR_W+1:0] leny_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              abort;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [ADDR_W:0]   cfg_len_x;
  logic [ADDR_W:0]   cfg_len_h;
  logic              cfg_shape;
  logic              cfg_err;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              x_we;
  logic              h_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W:0]   len_x;
  logic [ADDR_W:0]   len_h;
  logic [ADDR_W+1:0] len_y;
  logic              shape;
  logic              start;
  logic              conv_busy;
  logic              loader_busy;
  logic              loader_done;
  logic [2:0]        state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  // Pulse counters and observed writes, written only by the monitor.
  int start_cnt = 0;
  int done_cnt  = 0;
  int err_cnt   = 0;
  logic [SB_W-1:0] obs_q[$];

  // Expected writes {x_we, h_we, addr, data} and the sample stream.
  logic [SB_W-1:0] exp_q[$];
  data_t           samp_q[$];

  // Geometry of the last accepted configuration.
  int   last_lx = 0;
  int   last_lh = 0;
  int   last_ly = 0;
  logic last_shape = 1'b0;

  conv_input_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .abort       (abort),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_len_x   (cfg_len_x),
    .cfg_len_h   (cfg_len_h),
    .cfg_shape   (cfg_shape),
    .cfg_err     (cfg_err),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .x_we        (x_we),
    .h_we        (h_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .len_x       (len_x),
    .len_h       (len_h),
    .len_y       (len_y),
    .shape       (shape),
    .start       (start),
    .conv_busy   (conv_busy),
    .loader_busy (loader_busy),
    .loader_done (loader_done),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (x_we || h_we) obs_q.push_back({x_we, h_we, mem_addr, mem_wdata});
      if (start)        start_cnt++;
      if (loader_done)  done_cnt++;
      if (cfg_err)      err_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n     = 1'b0;
    abort     = 1'b0;
    cfg_valid = 1'b0;
    cfg_len_x = '0;
    cfg_len_h = '0;
    cfg_shape = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    conv_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Returns at #1 after the edge that took the config.
  task automatic send_cfg(input lenx_t lx, input lenx_t lh, input logic shp, output bit ok);
    int guard;
    guard     = 0;
    cfg_len_x = lx;
    cfg_len_h = lh;
    cfg_shape = shp;
    cfg_valid = 1'b1;
    while (!cfg_ready && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    ok = cfg_ready;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  // gap_mode: 0 = valid every cycle, 1 = idle cycle before each sample,
  // 2 = random idle cycles. Returns at #1 after the final accept edge.
  task automatic stream(input int gap_mode, output bit ok);
    int guard;
    ok = 1'b1;
    for (int i = 0; i < samp_q.size(); i++) begin
      if (gap_mode == 1) begin
        in_valid = 1'b0;
        in_data  = data_t'($urandom);
        @(posedge clk);
        #1;
      end else if (gap_mode == 2) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          in_data  = data_t'($urandom);
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_data  = samp_q[i];
      guard    = 0;
      while (!in_ready && guard < 100) begin
        @(posedge clk);
        #1;
        guard++;
      end
      if (!in_ready) begin
        ok       = 1'b0;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Full job: config, stream, start, busy handshake, done; checks everything.
  task automatic run_job(input int lx, input int lh, input logic shp, input int gap,
                         input int busy_cycles, input bit fixed_data);
    int  s0;
    int  d0;
    int  exp_ly;
    bit  ok;
    bit  busy_ok;
    s0 = start_cnt;
    d0 = done_cnt;
    samp_q.delete();
    exp_q.delete();
    obs_q.delete();
    for (int i = 0; i < lx + lh; i++)
      samp_q.push_back(fixed_data ? data_t'(i + 1) : data_t'($urandom_range(0, 255)));
    // Reference: X gets samples 0..lx-1 at addr 0.., H gets the rest at addr 0..
    for (int i = 0; i < lx; i++) exp_q.push_back({1'b1, 1'b0, addr_t'(i), samp_q[i]});
    for (int j = 0; j < lh; j++) exp_q.push_back({1'b0, 1'b1, addr_t'(j), samp_q[lx + j]});
    exp_ly = shp ? lx : lx + lh - 1;

    send_cfg(lenx_t'(lx), lenx_t'(lh), shp, ok);
    n_checks++;
    if (!ok) $display("FAIL cfg_accept: cfg_ready never rose");
    else n_pass++;

    n_checks++;
    if (len_y !== leny_t'(exp_ly))
      $display("FAIL len_y: got %0d expected %0d", len_y, exp_ly);
    else n_pass++;
    n_checks++;
    if ({len_x, len_h, shape} !== {lenx_t'(lx), lenx_t'(lh), shp})
      $display("FAIL latched_cfg: got x=%0d h=%0d s=%0d expected x=%0d h=%0d s=%0d",
               len_x, len_h, shape, lx, lh, shp);
    else n_pass++;

    stream(gap, ok);
    n_checks++;
    if (!ok) $display("FAIL stream_timeout: in_ready stayed low");
    else n_pass++;

    n_checks++;
    if ({start, h_we} !== 2'b11)
      $display("FAIL start_after_last: got start=%0b h_we=%0b expected 1 1", start, h_we);
    else n_pass++;

    // Convolution FSM stand-in: busy for busy_cycles, then idle.
    repeat (2) @(posedge clk);
    #1 conv_busy = 1'b1;
    busy_ok = 1'b1;
    for (int k = 0; k < busy_cycles; k++) begin
      @(posedge clk);
      #1;
      if (!loader_busy || loader_done) busy_ok = 1'b0;
    end
    conv_busy = 1'b0;
    n_checks++;
    if (!busy_ok) $display("FAIL busy_phase: loader_busy dropped or done early");
    else n_pass++;

    @(posedge clk);
    #1;
    n_checks++;
    if ({loader_done, cfg_ready, loader_busy} !== 3'b110)
      $display("FAIL done_pulse: got done=%0b cfg_ready=%0b busy=%0b expected 1 1 0",
               loader_done, cfg_ready, loader_busy);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (loader_done !== 1'b0) $display("FAIL done_width: got %0b expected 0", loader_done);
    else n_pass++;

    n_checks++;
    if ((start_cnt - s0) != 1 || (done_cnt - d0) != 1)
      $display("FAIL pulse_count: got start=%0d done=%0d expected 1 1",
               start_cnt - s0, done_cnt - d0);
    else n_pass++;

    n_checks++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL write_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL write[%0d]: got xwe=%0b hwe=%0b a=%0d d=%0d expected xwe=%0b hwe=%0b a=%0d d=%0d",
                 i, obs_q[i][SB_W-1], obs_q[i][SB_W-2], obs_q[i][DATA_W+:ADDR_W], obs_q[i][DATA_W-1:0],
                 exp_q[i][SB_W-1], exp_q[i][SB_W-2], exp_q[i][DATA_W+:ADDR_W], exp_q[i][DATA_W-1:0]);
      else n_pass++;
    end

    last_lx    = lx;
    last_lh    = lh;
    last_ly    = exp_ly;
    last_shape = shp;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({cfg_ready, in_ready, loader_busy} !== 3'b100)
      $display("FAIL reset_ready: got cfg_ready=%0b in_ready=%0b busy=%0b expected 1 0 0",
               cfg_ready, in_ready, loader_busy);
    else n_pass++;
    n_checks++;
    if ({x_we, h_we, start, cfg_err, loader_done} !== 5'b0)
      $display("FAIL reset_pulses: got %b expected 00000", {x_we, h_we, start, cfg_err, loader_done});
    else n_pass++;
    n_checks++;
    if ({len_x, len_h, len_y, shape} !== '0)
      $display("FAIL reset_lengths: got x=%0d h=%0d y=%0d s=%0b expected 0", len_x, len_h, len_y, shape);
    else n_pass++;
    n_checks++;
    if ({mem_addr, mem_wdata, state_dbg} !== '0)
      $display("FAIL reset_mem_state: got a=%0d d=%0d st=%0d expected 0", mem_addr, mem_wdata, state_dbg);
    else n_pass++;
  endtask

  task automatic test_basic();
    run_job(4, 3, 1'b0, 0, 3, 1'b1);
  endtask

  task automatic test_toggle();
    run_job(4, 3, 1'b0, 1, 4, 1'b1);
  endtask

  task automatic test_illegal();
    lenx_t bad_x[4];
    lenx_t bad_h[4];
    bit    ok;
    int    e0;
    bad_x = '{lenx_t'(0), lenx_t'(4), lenx_t'(33), lenx_t'(0)};
    bad_h = '{lenx_t'(3), lenx_t'(33), lenx_t'(5), lenx_t'(0)};
    for (int i = 0; i < 4; i++) begin
      e0 = err_cnt;
      send_cfg(bad_x[i], bad_h[i], 1'b1, ok);
      n_checks++;
      if ({cfg_err, cfg_ready, state_dbg} !== {1'b1, 1'b1, 3'd0})
        $display("FAIL cfg_err_pulse[%0d]: got err=%0b ready=%0b st=%0d expected 1 1 0",
                 i, cfg_err, cfg_ready, state_dbg);
      else n_pass++;
      @(posedge clk);
      #1;
      n_checks++;
      if (cfg_err !== 1'b0 || (err_cnt - e0) != 1)
        $display("FAIL cfg_err_width[%0d]: got err=%0b pulses=%0d expected 0 1", i, cfg_err, err_cnt - e0);
      else n_pass++;
      n_checks++;
      if ({len_x, len_h, len_y, shape} !== {lenx_t'(last_lx), lenx_t'(last_lh), leny_t'(last_ly), last_shape})
        $display("FAIL cfg_err_keep[%0d]: got x=%0d h=%0d y=%0d s=%0b expected x=%0d h=%0d y=%0d s=%0b",
                 i, len_x, len_h, len_y, shape, last_lx, last_lh, last_ly, last_shape);
      else n_pass++;
    end
  endtask

  task automatic test_max();
    run_job(32, 32, 1'b0, 0, 2, 1'b0);
    run_job(32, 1, 1'b1, 0, 2, 1'b0);
  endtask

  task automatic test_busy();
    run_job(5, 2, 1'b1, 0, 10, 1'b0);
  endtask

  task automatic test_abort();
    bit ok;
    int s0;
    samp_q.delete();
    exp_q.delete();
    obs_q.delete();
    // Three X samples plus one H sample, leaving the counter at 1 in LOAD_H.
    for (int i = 0; i < 4; i++) samp_q.push_back(data_t'($urandom_range(0, 255)));
    for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, 1'b0, addr_t'(i), samp_q[i]});
    exp_q.push_back({1'b0, 1'b1, addr_t'(0), samp_q[3]});
    send_cfg(lenx_t'(3), lenx_t'(4), 1'b1, ok);
    stream(0, ok);
    s0 = start_cnt;
    n_checks++;
    if (!ok || state_dbg !== 3'd2)
      $display("FAIL abort_setup: got state %0d expected 2", state_dbg);
    else n_pass++;

    in_valid = 1'b1;
    in_data  = data_t'($urandom);
    abort    = 1'b1;
    @(posedge clk);
    #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if ({h_we, x_we, start} !== 3'b000)
      $display("FAIL abort_suppress: got h_we=%0b x_we=%0b start=%0b expected 0 0 0", h_we, x_we, start);
    else n_pass++;
    n_checks++;
    if ({state_dbg, cfg_ready, loader_busy} !== {3'd0, 1'b1, 1'b0})
      $display("FAIL abort_idle: got st=%0d ready=%0b busy=%0b expected 0 1 0", state_dbg, cfg_ready, loader_busy);
    else n_pass++;
    n_checks++;
    if ({len_x, len_h, len_y, shape} !== {lenx_t'(3), lenx_t'(4), leny_t'(3), 1'b1})
      $display("FAIL abort_keep: got x=%0d h=%0d y=%0d s=%0b expected 3 4 3 1", len_x, len_h, len_y, shape);
    else n_pass++;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (start_cnt != s0) $display("FAIL abort_no_start: got %0d start pulses expected 0", start_cnt - s0);
    else n_pass++;
    n_checks++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL abort_writes: got %0d writes expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL abort_write[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    // A fresh job after abort must run normally.
    run_job($urandom_range(1, 8), $urandom_range(1, 8), 1'($urandom_range(0, 1)), 0, 3, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++)
      run_job($urandom_range(1, 32), $urandom_range(1, 32), 1'($urandom_range(0, 1)), 2,
              $urandom_range(1, 6), 1'b0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_toggle();
    test_illegal();
    test_max();
    test_busy();
    test_abort();
    test_random();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/conv_input_loader.md
Name: conv_input_loader

Overview:
Upstream feeder for the convolution control FSM and its datapath. Accepts a configuration word (sequence lengths, shape mode), then streams x samples and h coefficients over a valid/ready interface into the X and H sample memories. Once both memories are loaded it issues a one-cycle Start to the convolution FSM, tracks its busy/done, and returns to idle.

Parameters:
DATA_W, 8, sample/coefficient width
ADDR_W, 5, memory address width; max sequence length = 2**ADDR_W

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
abort  in  1  synchronous soft clear; returns block to IDLE
cfg_valid  in  1  configuration offered
cfg_ready  out  1  high only in IDLE
cfg_len_x  in  ADDR_W+1  number of x samples, legal 1..2**ADDR_W
cfg_len_h  in  ADDR_W+1  number of h coefficients, legal 1..2**ADDR_W
cfg_shape  in  1  0 = full convolution, 1 = same-size output
cfg_err  out  1  one-cycle pulse: illegal config rejected
in_valid  in  1  stream sample offered
in_ready  out  1  high in LOAD_X and LOAD_H
in_data  in  DATA_W  stream sample
x_we  out  1  X memory write enable
h_we  out  1  H memory write enable
mem_addr  out  ADDR_W  write address (shared by X/H)
mem_wdata  out  DATA_W  write data
len_x  out  ADDR_W+1  latched x length, held for datapath
len_h  out  ADDR_W+1  latched h length, held for datapath
len_y  out  ADDR_W+2  len_x + len_h - 1 (full) or len_x (same)
shape  out  1  latched cfg_shape, drives FSM shape input
start  out  1  one-cycle pulse to convolution FSM Start
conv_busy  in  1  busy from convolution FSM
loader_busy  out  1  high in every state except IDLE
loader_done  out  1  one-cycle pulse when convolution finishes

Behaviour:
- Reset (rst_n low, async): state IDLE; all outputs 0 except cfg_ready=1; len_x, len_h, len_y, shape = 0; address counter = 0.
- States: IDLE, LOAD_X, LOAD_H, START, WAIT_BUSY, WAIT_DONE.
- IDLE: cfg_ready=1. On cfg_valid: if either length is 0 or exceeds 2**ADDR_W, pulse cfg_err next cycle and stay in IDLE, latches unchanged. Otherwise latch lengths and shape, compute len_y (registered, valid the cycle after acceptance), clear the counter, and go to LOAD_X.
- LOAD_X: in_ready=1. On each in_valid&in_ready, the next cycle drives x_we=1, mem_addr=counter, mem_wdata=in_data (registered, 1-cycle latency). Counter increments. The accept with counter==len_x-1 moves to LOAD_H and clears the counter.
- LOAD_H: same as LOAD_X, but drives h_we. The accept with counter==len_h-1 moves to START.
- The last write (x_we or h_we) is asserted in the cycle after the final accept. x_we and h_we are never high together.
- START: start=1 for exactly one cycle. This cycle coincides with the registered write of the final h sample, so memory contents are committed by the FSM's first read, two cycles later. Next state WAIT_BUSY.
- WAIT_BUSY: wait for conv_busy=1, then go to WAIT_DONE. There is no timeout.
- WAIT_DONE: wait for conv_busy=0. On that cycle, pulse loader_done next cycle and return to IDLE. len_x, len_h, len_y and shape are held until the next accepted config.
- abort (any state): next state IDLE and counter cleared. Pending write enables and start are suppressed in the following cycle. Latched lengths are kept.
- abort takes priority over simultaneous cfg_valid, in_valid or conv_busy events.
- Reset mid-load: memories are not cleared. The loader simply restarts from IDLE.
- Counter is ADDR_W+1 bits. When len = 2**ADDR_W the final address is 2**ADDR_W-1; mem_addr uses the low ADDR_W bits and never wraps.
- len_y width ADDR_W+2 holds the maximum 2**(ADDR_W+1)-1 without overflow.

Decomposition:
- Shared package conv_pkg: loader state enum, DATA_W/ADDR_W defaults, the shape encoding constants (SHAPE_FULL=0, SHAPE_SAME=1).
- One sub-module is natural: conv_len_counter, a loadable up-counter with clear, enable and terminal-count compare against a length input. Instantiate it once and share it between the LOAD_X and LOAD_H phases.

Test Plan:
1. Config len_x=4, len_h=3, shape=0; stream 1,2,3,4,5,6,7 with in_valid constant.
   -> X writes at addr 0..3 with data 1..4; H writes at addr 0..2 with data 5..7; len_y=6; one start pulse in the cycle after the last accept.
2. Same config, in_valid toggling every other cycle.
   -> Identical memory contents and addresses; no write on idle cycles; start issued once.
3. Config len_x=0, then len_h=33 with ADDR_W=5.
   -> cfg_err pulse each time; state stays IDLE; len_x/len_h keep their previous values.
4. Config len_x=32, len_h=32.
   -> Last X address 31, no wrap; len_y=63.
5. After start, model FSM busy high for 10 cycles, then low.
   -> loader_busy high throughout; loader_done pulses one cycle after busy falls; cfg_ready returns to 1.
6. abort asserted mid-LOAD_H at counter=1, with in_valid also high.
   -> No h_we next cycle; state IDLE; no start; a new config is then accepted normally.
